// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write bus.
//   master: loader side, drives the write strobe, byte address and data.
//   slave : memory side, receives them.
// The address and data hold their last values whenever imem_we is low.
interface imem_uart_loader_if #(
  parameter int I_ADDR_W = 12,
  parameter int INST_W   = 16
);
  logic                imem_we;
  logic [I_ADDR_W-1:0] imem_waddr;
  logic [INST_W-1:0]   imem_wdata;

  modport master (output imem_we, imem_waddr, imem_wdata);
  modport slave  (input  imem_we, imem_waddr, imem_wdata);
endinterface

// File: rtl/imem_uart_loader.sv
// Serial program loader. Receives 8N1 bytes on uart_rx, parses the frame
//   A5, LEN_LO, LEN_HI, LEN x {INST_LO, INST_HI}, CSUM
// and writes one 16-bit instruction per word into instruction memory.
// The CPU is held while a load is in progress or after a failed load.
// Ports:
//   clk, reset_n  single clock, asynchronous active-low reset
//   uart_rx       serial input, idle high, asynchronous to clk
//   imem          write bus (imem_we / imem_waddr / imem_wdata)
//   cpu_hold      1 = keep the CPU in reset
//   load_done     one-cycle pulse on a good checksum
//   load_error    sticky; cleared when the next sync byte is accepted
module imem_uart_loader #(
  parameter int CLKS_PER_BIT = 104,
  parameter int I_ADDR_W     = 12,
  parameter int INST_W       = 16,
  parameter int TIMEOUT_CLKS = 1000000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               uart_rx,
  imem_uart_loader_if.master imem,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_error
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam int IDX_W = I_ADDR_W - 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TMO_W-1:0] TMO_M1  = TMO_W'(TIMEOUT_CLKS - 1);
  localparam logic [15:0]      MAX_LEN = 16'((1 << I_ADDR_W) / 2);

  // ---------------- input synchronizer (preset to idle level) ----------------
  logic rx_meta_q, rx_sync_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // ---------------- UART receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
  rx_st_t           rx_st_q, rx_st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             byte_valid, frame_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_st_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      rx_st_q <= rx_st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  // byte_valid / frame_err are asserted in the stop-sample cycle itself so the
  // loader registers its response on the following edge.
  always_comb begin
    rx_st_d    = rx_st_q;
    cnt_d      = cnt_q + CNT_W'(1);
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_sync_q) begin
          rx_st_d = RX_START;
          bit_d   = '0;
        end
      end
      RX_START: if (cnt_q == HALF_M1) begin
        cnt_d   = '0;
        rx_st_d = rx_sync_q ? RX_IDLE : RX_DATA;  // high at mid-start = glitch
      end
      RX_DATA: if (cnt_q == FULL_M1) begin
        cnt_d   = '0;
        shreg_d = {rx_sync_q, shreg_q[7:1]};      // LSB first
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) rx_st_d = RX_STOP;
      end
      RX_STOP: if (cnt_q == FULL_M1) begin
        cnt_d      = '0;
        rx_st_d    = RX_IDLE;
        byte_valid = rx_sync_q;
        frame_err  = !rx_sync_q;
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // ---------------- frame loader ----------------
  typedef enum logic [2:0] {
    LD_WAIT_SYNC, LD_LEN_LO, LD_LEN_HI, LD_DATA_LO, LD_DATA_HI, LD_CSUM
  } ld_st_t;
  ld_st_t              ld_st_q, ld_st_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [7:0]          sum_q, sum_d;
  logic [7:0]          lo_q, lo_d;       // LEN_LO, then each INST_LO
  logic [15:0]         len_q, len_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                we_q, we_d;
  logic [I_ADDR_W-1:0] waddr_q, waddr_d;
  logic [INST_W-1:0]   wdata_q, wdata_d;
  logic                hold_q, hold_d, done_q, done_d, err_q, err_d;
  logic                fail;
  logic [15:0]         idx_nxt, len_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_st_q <= LD_WAIT_SYNC;
      idx_q   <= '0;
      sum_q   <= '0;
      lo_q    <= '0;
      len_q   <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ld_st_q <= ld_st_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      lo_q    <= lo_d;
      len_q   <= len_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // LEN is 16 bits but idx is only I_ADDR_W-1 bits, so compare at 16 bits.
  assign idx_nxt = 16'(idx_q) + 16'd1;
  assign len_in  = {shreg_q, lo_q};

  always_comb begin
    ld_st_d = ld_st_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    lo_d    = lo_q;
    len_d   = len_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    err_d   = err_q;
    fail    = 1'b0;
    tmo_d   = (ld_st_q == LD_WAIT_SYNC || byte_valid) ? '0 : tmo_q + TMO_W'(1);
    if (byte_valid) begin
      case (ld_st_q)
        LD_WAIT_SYNC: if (shreg_q == 8'hA5) begin
          ld_st_d = LD_LEN_LO;
          hold_d  = 1'b1;
          err_d   = 1'b0;
          idx_d   = '0;
          sum_d   = '0;
        end
        LD_LEN_LO: begin
          lo_d    = shreg_q;
          sum_d   = sum_q + shreg_q;
          ld_st_d = LD_LEN_HI;
        end
        LD_LEN_HI: begin
          len_d = len_in;
          sum_d = sum_q + shreg_q;
          if (len_in == 16'd0 || len_in > MAX_LEN) fail = 1'b1;
          else                                     ld_st_d = LD_DATA_LO;
        end
        LD_DATA_LO: begin
          lo_d    = shreg_q;
          sum_d   = sum_q + shreg_q;
          ld_st_d = LD_DATA_HI;
        end
        LD_DATA_HI: begin
          we_d    = 1'b1;
          waddr_d = {idx_q, 1'b0};
          wdata_d = INST_W'({shreg_q, lo_q});
          idx_d   = idx_q + IDX_W'(1);
          sum_d   = sum_q + shreg_q;
          ld_st_d = (idx_nxt == len_q) ? LD_CSUM : LD_DATA_LO;
        end
        LD_CSUM: begin
          if (shreg_q == sum_q) begin
            done_d  = 1'b1;
            hold_d  = 1'b0;
            ld_st_d = LD_WAIT_SYNC;
          end else begin
            fail = 1'b1;
          end
        end
        default: ld_st_d = LD_WAIT_SYNC;
      endcase
    end else if (ld_st_q != LD_WAIT_SYNC && (frame_err || tmo_q == TMO_M1)) begin
      fail = 1'b1;
    end
    // Failure leaves cpu_hold asserted; written memory is not rolled back.
    if (fail) begin
      err_d   = 1'b1;
      ld_st_d = LD_WAIT_SYNC;
    end
  end

  assign imem.imem_we    = we_q;
  assign imem.imem_waddr = waddr_q;
  assign imem.imem_wdata = wdata_q;
  assign cpu_hold        = hold_q;
  assign load_done       = done_q;
  assign load_error      = err_q;
endmodule

// File: tb/tb_imem_uart_loader.sv
module tb_imem_uart_loader;
  localparam int CPB = 16;
  localparam int TMO = 3000;

  logic clk = 1'b0, reset_n = 1'b0, uart_rx = 1'b1;
  logic cpu_hold, load_done, load_error;
  int   pass_cnt = 0, total_cnt = 0, done_cnt = 0;
  logic [11:0] wa[$];
  logic [15:0] wd[$];
  logic [7:0]  frm[$];

  imem_uart_loader_if #(.I_ADDR_W(12), .INST_W(16)) imem_if ();

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .I_ADDR_W(12), .INST_W(16), .TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx), .imem(imem_if),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_if.imem_we) begin
      wa.push_back(imem_if.imem_waddr);
      wd.push_back(imem_if.imem_wdata);
    end
    if (load_done) done_cnt++;
  end

  task automatic clr();
    wa.delete(); wd.delete(); done_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk); uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (CPB * 2) @(negedge clk);
  endtask

  task automatic send_frm();
    foreach (frm[i]) send_byte(frm[i], 1'b1);
    repeat (CPB * 4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    total_cnt++; if ({imem_if.imem_we, cpu_hold, load_done, load_error} !== 4'b0) $display("FAIL reset_outs got %b exp 0000", {imem_if.imem_we, cpu_hold, load_done, load_error}); else pass_cnt++;
    total_cnt++; if ({imem_if.imem_waddr, imem_if.imem_wdata} !== 28'h0) $display("FAIL reset_bus got %h exp 0", {imem_if.imem_waddr, imem_if.imem_wdata}); else pass_cnt++;
    reset_n = 1'b1; clr();
    repeat (2000) @(negedge clk);
    total_cnt++; if (wa.size() !== 0) $display("FAIL idle_writes got %0d exp 0", wa.size()); else pass_cnt++;
    total_cnt++; if ({cpu_hold, load_error, done_cnt != 0} !== 3'b0) $display("FAIL idle_outs got %b exp 000", {cpu_hold, load_error, done_cnt != 0}); else pass_cnt++;
  endtask

  task automatic test_good_frame();
    clr();
    send_byte(8'hA5, 1'b1);
    total_cnt++; if (cpu_hold !== 1'b1) $display("FAIL good_hold_after_sync got %b exp 1", cpu_hold); else pass_cnt++;
    frm = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h16};
    send_frm();
    total_cnt++; if (wa.size() !== 2) $display("FAIL good_wr_count got %0d exp 2", wa.size()); else pass_cnt++;
    if (wa.size() == 2) begin
      total_cnt++; if ({wa[0], wd[0]} !== {12'h000, 16'h1234}) $display("FAIL good_wr0 got %h/%h exp 000/1234", wa[0], wd[0]); else pass_cnt++;
      total_cnt++; if ({wa[1], wd[1]} !== {12'h002, 16'h5678}) $display("FAIL good_wr1 got %h/%h exp 002/5678", wa[1], wd[1]); else pass_cnt++;
    end
    total_cnt++; if (done_cnt !== 1) $display("FAIL good_done got %0d exp 1", done_cnt); else pass_cnt++;
    total_cnt++; if ({cpu_hold, load_error} !== 2'b00) $display("FAIL good_hold_err got %b exp 00", {cpu_hold, load_error}); else pass_cnt++;
  endtask

  task automatic test_bad_csum();
    clr();
    frm = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h17};
    send_frm();
    total_cnt++; if (wa.size() !== 2) $display("FAIL csum_wr_count got %0d exp 2", wa.size()); else pass_cnt++;
    total_cnt++; if ({load_error, cpu_hold} !== 2'b11) $display("FAIL csum_err_hold got %b exp 11", {load_error, cpu_hold}); else pass_cnt++;
    total_cnt++; if (done_cnt !== 0) $display("FAIL csum_done got %0d exp 0", done_cnt); else pass_cnt++;
    clr();
    frm = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h16};
    send_frm();
    total_cnt++; if ({load_error, cpu_hold, done_cnt == 1} !== 3'b001) $display("FAIL csum_recover got %b exp 001", {load_error, cpu_hold, done_cnt == 1}); else pass_cnt++;
  endtask

  task automatic test_random();
    clr();
    frm = '{8'h3C, 8'hFF, 8'h00, 8'h5A, 8'hA4};
    send_frm();
    total_cnt++; if ({wa.size() != 0, cpu_hold, load_error, done_cnt != 0} !== 4'b0) $display("FAIL random_ignored got %b exp 0000", {wa.size() != 0, cpu_hold, load_error, done_cnt != 0}); else pass_cnt++;
  endtask

  task automatic test_bad_len();
    clr();
    frm = '{8'hA5, 8'h00, 8'h00};
    send_frm();
    total_cnt++; if ({load_error, cpu_hold, wa.size() != 0} !== 3'b110) $display("FAIL len0 got %b exp 110", {load_error, cpu_hold, wa.size() != 0}); else pass_cnt++;
    send_byte(8'hA5, 1'b1);
    total_cnt++; if (load_error !== 1'b0) $display("FAIL sync_clears_err got %b exp 0", load_error); else pass_cnt++;
    frm = '{8'h01, 8'h08, 8'h00, 8'h00};
    send_frm();
    total_cnt++; if ({load_error, cpu_hold, wa.size() != 0} !== 3'b110) $display("FAIL len2049 got %b exp 110", {load_error, cpu_hold, wa.size() != 0}); else pass_cnt++;
  endtask

  task automatic test_glitch();
    clr();
    frm = '{8'hA5, 8'h01, 8'h00};
    send_frm();
    @(negedge clk); uart_rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (CPB * 12) @(negedge clk);
    frm = '{8'hEF, 8'hBE, 8'hAE};   // 01+00+EF+BE = 1AE
    send_frm();
    total_cnt++; if ({load_error, cpu_hold, done_cnt == 1, wa.size() == 1} !== 4'b0011) $display("FAIL glitch_frame got %b exp 0011", {load_error, cpu_hold, done_cnt == 1, wa.size() == 1}); else pass_cnt++;
    if (wa.size() == 1) begin
      total_cnt++; if ({wa[0], wd[0]} !== {12'h000, 16'hBEEF}) $display("FAIL glitch_wr got %h/%h exp 000/beef", wa[0], wd[0]); else pass_cnt++;
    end
  endtask

  task automatic test_stop_err();
    clr();
    frm = '{8'hA5, 8'h01, 8'h00};
    send_frm();
    send_byte(8'h34, 1'b0);
    repeat (CPB * 20) @(negedge clk);
    total_cnt++; if ({load_error, cpu_hold, wa.size() != 0} !== 3'b110) $display("FAIL stop_err got %b exp 110", {load_error, cpu_hold, wa.size() != 0}); else pass_cnt++;
  endtask

  task automatic test_timeout();
    clr();
    frm = '{8'hA5, 8'h01, 8'h00};
    send_frm();
    total_cnt++; if (load_error !== 1'b0) $display("FAIL tmo_before got %b exp 0", load_error); else pass_cnt++;
    repeat (TMO) @(negedge clk);
    total_cnt++; if ({load_error, cpu_hold} !== 2'b11) $display("FAIL tmo_after got %b exp 11", {load_error, cpu_hold}); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    clr();
    frm = '{8'hA5, 8'h02, 8'h00, 8'h34};
    send_frm();
    @(negedge clk); uart_rx = 1'b0;
    repeat (CPB * 4) @(negedge clk);
    total_cnt++; if (wa.size() !== 0) $display("FAIL mid_prewrites got %0d exp 0", wa.size()); else pass_cnt++;
    reset_n = 1'b0;
    #1;
    total_cnt++; if ({imem_if.imem_we, cpu_hold, load_done, load_error} !== 4'b0) $display("FAIL mid_reset_outs got %b exp 0000", {imem_if.imem_we, cpu_hold, load_done, load_error}); else pass_cnt++;
    uart_rx = 1'b1;
    repeat (10) @(negedge clk);
    reset_n = 1'b1;
    repeat (CPB * 12) @(negedge clk);
    total_cnt++; if (wa.size() !== 0) $display("FAIL mid_abort_writes got %0d exp 0", wa.size()); else pass_cnt++;
    clr();
    frm = '{8'hA5, 8'h01, 8'h00, 8'hCD, 8'hAB, 8'h79};
    send_frm();
    total_cnt++; if ({load_error, cpu_hold, done_cnt == 1, wa.size() == 1} !== 4'b0011) $display("FAIL mid_reload got %b exp 0011", {load_error, cpu_hold, done_cnt == 1, wa.size() == 1}); else pass_cnt++;
    if (wa.size() == 1) begin
      total_cnt++; if ({wa[0], wd[0]} !== {12'h000, 16'hABCD}) $display("FAIL mid_reload_wr got %h/%h exp 000/abcd", wa[0], wd[0]); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_random();
    test_bad_len();
    test_glitch();
    test_stop_err();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
